// File: rtl/alu_2b_array.sv
// Eight-lane 16-bit ALU stage: per-lane add/sub/move/pass-through on 2-byte
// containers, two-stage pipeline with a one-entry skid buffer for backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   alu_in_valid         operand beat valid; accepted when ready_out is high
//   alu_in_2B_1/_2       operand A / B, lane i at [(i+1)*width_2B-1 -: width_2B]
//   action_in            action bundle; lane i word at [(i+2)*ACT_LEN-1 -: ACT_LEN]
//   ready_out            registered: high whenever the skid entry is empty
//   container_out_2B     result containers, same lane packing as the operands
//   container_out_valid  result beat valid (held stable while ready_in is low)
//   ready_in             downstream accepts the result beat
//   phv_cnt              wrapping count of delivered result beats
module alu_2b_array #(
    parameter int STAGE_ID = 0,
    parameter int ACT_LEN  = 25,
    parameter int width_2B = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_in_valid,
    input  logic [width_2B*8-1:0]   alu_in_2B_1,
    input  logic [width_2B*8-1:0]   alu_in_2B_2,
    input  logic [ACT_LEN*25-1:0]   action_in,
    output logic                    ready_out,
    output logic [width_2B*8-1:0]   container_out_2B,
    output logic                    container_out_valid,
    input  logic                    ready_in,
    output logic [31:0]             phv_cnt
);

    localparam int NL = 8;
    localparam int LW = width_2B;
    localparam int DW = LW * NL;

    typedef struct packed {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [NL*4-1:0] op;
    } beat_t;

    function automatic logic [DW-1:0] alu_f(input beat_t bt);
        logic [DW-1:0] r;
        logic [3:0]    op;
        logic [LW-1:0] av;
        logic [LW-1:0] bv;
        logic          is_add;
        logic          is_sub;
        logic          is_mov;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            op = bt.op[i*4 +: 4];
            av = bt.a[i*LW +: LW];
            bv = bt.b[i*LW +: LW];
            // Bit 3 of the opcode is a don't-care for add and sub.
            is_add = (op[2:0] == 3'b001);
            is_sub = (op[2:0] == 3'b010);
            is_mov = (op == 4'b1110);
            unique case (1'b1)
                is_add:  r[i*LW +: LW] = av + bv;
                is_sub:  r[i*LW +: LW] = av - bv;
                is_mov:  r[i*LW +: LW] = bv;
                default: r[i*LW +: LW] = av;
            endcase
        end
        return r;
    endfunction

    beat_t         in_beat;
    logic          accept;
    logic          advance;
    logic          s1_load;

    logic          s1_valid_q, s1_valid_d;
    beat_t         s1_beat_q, s1_beat_d;
    logic          skid_valid_q, skid_valid_d;
    beat_t         skid_beat_q, skid_beat_d;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_res_q, s2_res_d;
    logic [31:0]   phv_cnt_q, phv_cnt_d;

    // Only the opcode field of each action word is consumed here.
    logic unused_act;
    assign unused_act = ^{action_in, 32'(STAGE_ID)};

    always_comb begin
        in_beat.a  = alu_in_2B_1;
        in_beat.b  = alu_in_2B_2;
        in_beat.op = '0;
        for (int i = 0; i < NL; i++) begin
            in_beat.op[i*4 +: 4] = action_in[(i+1)*ACT_LEN + 24 -: 4];
        end
    end

    // accept cannot coincide with an occupied skid, so a skid refill into
    // S1 never collides with a new beat.
    assign accept  = alu_in_valid & ~skid_valid_q;
    assign advance = ~s2_valid_q | ready_in;
    assign s1_load = ~s1_valid_q | advance;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_beat_d    = s1_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        s2_valid_d   = s2_valid_q;
        s2_res_d     = s2_res_q;
        phv_cnt_d    = phv_cnt_q;

        if (s1_load) begin
            if (skid_valid_q) begin
                s1_valid_d   = 1'b1;
                s1_beat_d    = skid_beat_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                s1_valid_d = 1'b1;
                s1_beat_d  = in_beat;
            end else begin
                s1_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = in_beat;
        end

        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_res_d   = alu_f(s1_beat_q);
        end

        if (s2_valid_q && ready_in) begin
            phv_cnt_d = phv_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_beat_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            s2_valid_q   <= 1'b0;
            s2_res_q     <= '0;
            phv_cnt_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_beat_q    <= s1_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            s2_valid_q   <= s2_valid_d;
            s2_res_q     <= s2_res_d;
            phv_cnt_q    <= phv_cnt_d;
        end
    end

    assign ready_out           = ~skid_valid_q;
    assign container_out_2B    = s2_res_q;
    assign container_out_valid = s2_valid_q;
    assign phv_cnt             = phv_cnt_q;

endmodule

// File: tb/tb_alu_2b_array.sv
// Randomized scoreboard bench for alu_2b_array: stimulus pushes reference
// results, a negedge monitor pops and compares delivered beats.
module tb_alu_2b_array;

    localparam int DW = 128;
    localparam int AW = 625;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_in_valid = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic [AW-1:0] act_in = '0;
    logic          ready_in = 1'b0;
    logic          ready_out;
    logic [DW-1:0] cout;
    logic          cout_valid;
    logic [31:0]   phv_cnt;

    alu_2b_array dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .alu_in_valid        (alu_in_valid),
        .alu_in_2B_1         (a_in),
        .alu_in_2B_2         (b_in),
        .action_in           (act_in),
        .ready_out           (ready_out),
        .container_out_2B    (cout),
        .container_out_valid (cout_valid),
        .ready_in            (ready_in),
        .phv_cnt             (phv_cnt)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_cnt = 0;
    bit            rnd_ready = 0;
    logic [DW-1:0] held;
    bit            held_v = 0;

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Reference: lane rules applied with plain integer arithmetic.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [AW-1:0] act);
        logic [DW-1:0] r;
        logic [24:0]   w;
        int            av, bv, rv, op;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            av = int'(a[i*16 +: 16]);
            bv = int'(b[i*16 +: 16]);
            w  = act[(i+2)*25-1 -: 25];
            op = int'(w[24:21]);
            case (op)
                1, 9:    rv = (av + bv) % 65536;
                2, 10:   rv = (av - bv + 65536) % 65536;
                14:      rv = bv;
                default: rv = av;
            endcase
            r[i*16 +: 16] = 16'(rv);
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] put_op(input logic [AW-1:0] act,
                                             input int lane,
                                             input logic [3:0] op);
        logic [24:0] w;
        w = act[(lane+2)*25-1 -: 25];
        w[24:21] = op;
        act[(lane+2)*25-1 -: 25] = w;
        return act;
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rand_act();
        logic [AW-1:0] r;
        for (int k = 0; k < AW; k++) r[k] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Monitor: compare delivered beats, check hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v  = 0;
            exp_cnt = 0;
        end else if (cout_valid) begin
            if (held_v) check("hold_stable", cout, held);
            if (ready_in) begin
                exp_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h required none", cout);
                end else begin
                    check("beat_data", cout, exp_q.pop_front());
                end
                held_v = 0;
            end else begin
                held   = cout;
                held_v = 1;
            end
        end else begin
            held_v = 0;
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #2;
            ready_in = ($urandom_range(0, 9) < 7);
        end
    end

    // Called and returns at posedge+2.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [AW-1:0] act);
        int t = 0;
        alu_in_valid = 1'b1;
        a_in   = a;
        b_in   = b;
        act_in = act;
        while (!ready_out && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (!ready_out) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got ready_out 0 required 1");
        end else begin
            exp_q.push_back(model(a, b, act));
            @(posedge clk);
            #2;
        end
        alu_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending required 0",
                     exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #2;
    endtask

    // Single beat with ready_in high: output must appear exactly at N+2.
    task automatic send_lat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [AW-1:0] act,
                            output logic [DW-1:0] res);
        send(a, b, act);
        check("latency_n1", 128'(cout_valid), 128'(0));
        @(posedge clk);
        #2;
        check("latency_n2", 128'(cout_valid), 128'(1));
        res = cout;
    endtask

    initial begin
        logic [DW-1:0] a, b, res;
        logic [AW-1:0] act;
        bit            saw_drop;

        repeat (3) @(posedge clk);
        #2;
        check("rst_ready_out", 128'(ready_out), 128'(1));
        check("rst_valid", 128'(cout_valid), 128'(0));
        check("rst_data", cout, 128'(0));
        check("rst_phv_cnt", 128'(phv_cnt), 128'(0));
        rst_n    = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #2;

        // Back-to-back burst with a 3-cycle stall from the first output.
        saw_drop = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(rand128(), rand128(), rand_act());
            end
            begin
                int t = 0;
                while (!cout_valid && t < 20) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                ready_in = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #2;
                    if (!ready_out) saw_drop = 1;
                end
                ready_in = 1'b1;
            end
        join
        check("stall_ready_drop", 128'(saw_drop), 128'(1));
        drain();
        check("burst_phv_cnt", 128'(phv_cnt), 128'(4));

        // Lane0 add, all other lanes pass A.
        a = rand128();
        b = rand128();
        act = '0;
        a[15:0] = 16'h0005;
        b[15:0] = 16'h0003;
        act = put_op(act, 0, 4'b0001);
        send_lat(a, b, act, res);
        check("lane0_add", 128'(res[15:0]), 128'(16'h0008));
        check("pass_lanes", 128'(res[127:16]), 128'(a[127:16]));
        drain();

        // Subtract wrap and add wrap.
        a = rand128();
        b = rand128();
        act = rand_act();
        a[127:112] = 16'h0000;
        b[127:112] = 16'h0001;
        act = put_op(act, 7, 4'b1010);
        a[63:48] = 16'hFFFF;
        b[63:48] = 16'h0002;
        act = put_op(act, 3, 4'b1001);
        send_lat(a, b, act, res);
        check("lane7_sub_wrap", 128'(res[127:112]), 128'(16'hFFFF));
        check("lane3_add_wrap", 128'(res[63:48]), 128'(16'h0001));
        drain();

        // Move B and unlisted opcode.
        a = rand128();
        b = rand128();
        act = rand_act();
        a[95:80] = 16'h1234;
        b[95:80] = 16'h00AB;
        act = put_op(act, 5, 4'b1110);
        a[47:32] = 16'h4321;
        act = put_op(act, 2, 4'b0111);
        send_lat(a, b, act, res);
        check("lane5_mov_b", 128'(res[95:80]), 128'(16'h00AB));
        check("lane2_pass_a", 128'(res[47:32]), 128'(16'h4321));
        drain();

        // Randomized stream with random backpressure.
        rnd_ready = 1;
        for (int n = 0; n < 200; n++) begin
            act = rand_act();
            for (int l = 0; l < 8; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 4))
                        0: act = put_op(act, l, 4'd1);
                        1: act = put_op(act, l, 4'd9);
                        2: act = put_op(act, l, 4'd2);
                        3: act = put_op(act, l, 4'd10);
                        default: act = put_op(act, l, 4'd14);
                    endcase
                end
            end
            send(rand128(), rand128(), act);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        rnd_ready = 0;
        repeat (2) @(posedge clk);
        #3;
        ready_in = 1'b1;
        drain();
        check("random_phv_cnt", 128'(phv_cnt), 128'(exp_cnt));

        // Fill S2, S1 and skid, then reset mid-flight.
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) send(rand128(), rand128(), rand_act());
        check("skid_full_ready", 128'(ready_out), 128'(0));
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_ready", 128'(ready_out), 128'(1));
        check("async_rst_valid", 128'(cout_valid), 128'(0));
        check("async_rst_data", cout, 128'(0));
        check("async_rst_phv", 128'(phv_cnt), 128'(0));
        ready_in = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        saw_drop = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            if (cout_valid || !ready_out) saw_drop = 1;
        end
        check("post_rst_quiet", 128'(saw_drop), 128'(0));

        // Counter wrap.
        force dut.phv_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.phv_cnt_q;
        #1;
        check("phv_preload", 128'(phv_cnt), 128'(32'hFFFF_FFFF));
        @(posedge clk);
        #2;
        send(rand128(), rand128(), rand_act());
        drain();
        check("phv_wrap", 128'(phv_cnt), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
